uart_rx_flow: RTL and testbench
===============================

# uart_rx_flow

UART receiver with a byte FIFO and hardware flow control, forming the receive end of the 8N1 serial link whose far side transmits to the system. It oversamples the serial input with a programmable bit divider, assembles bytes, buffers them in a show-ahead FIFO and drives an RTS output that throttles the remote transmitter as the FIFO fills. Downstream logic drains bytes through a valid/ready handshake.

## Interface
- CLK_DIV, 868: clock cycles per bit (100 MHz / 115200); legal range ≥ 4, at most 16 bits.
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 bytes.
- RTS_MARGIN, 4: free slots kept in reserve; must be ≥ 1 and < 2**DEPTH_LOG2.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- rts  out  1  active-high "ready to receive" to the remote end; board top inverts it for RTS_n.
- data_o  out  8  FIFO head byte.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o when valid_o is also high.
- level_o  out  DEPTH_LOG2+1  FIFO occupancy.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err_o  out  1  one-cycle pulse: byte dropped because the FIFO was full.

## Operation
- Input path: 2-FF synchronizer on rxd, plus one further register holding the previous synchronized value. All three reset to 1.
- FSM states: IDLE, START, DATA, STOP. Reset state: IDLE.
- Bit counter cnt is 16 bits; bit index idx is 3 bits; shift register is 8 bits.
- IDLE -> START on a falling edge of the synchronized rxd (previous = 1, current = 0). Load cnt = CLK_DIV/2 − 1 (integer division). A line held low does not retrigger.
- Every state except IDLE decrements cnt each cycle. The sample event is cnt == 0; on that cycle cnt reloads CLK_DIV − 1.
- START sample:
  - 0 -> DATA with idx = 0.
  - 1 -> glitch; return to IDLE with no side effects.
- DATA sample: shift in the bit, LSB first. After idx == 7 go to STOP; otherwise increment idx.
- STOP sample, then always go to IDLE:
  - 1 and FIFO can accept -> push the byte.
  - 1 and FIFO cannot accept -> drop the byte and pulse overrun_err_o.
  - 0 -> drop the byte and pulse frame_err_o. No overrun check is made.
- FIFO: circular buffer with DEPTH_LOG2-bit read and write pointers (wrap naturally) and a separate level counter.
  - Pop when valid_o && ready_i.
  - Push is accepted when level < DEPTH, or when a pop occurs in the same cycle.
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - data_o is the buffer entry at the read pointer. It is undefined (don't care) when valid_o = 0.
- rts register: next value = (level_next < DEPTH − RTS_MARGIN), where level_next is the post-update occupancy.

## Timing
- Reset values: rts = 0, valid_o = 0, level_o = 0, frame_err_o = 0, overrun_err_o = 0, data_o = 0. FIFO pointers are cleared.
- First cycle after reset deasserts: rts = 1.
- Reset in any state aborts the frame immediately and empties the FIFO. Bits already in flight are discarded.
- Synchronizer latency: 2 cycles from an rxd change to the synchronized value.
- Sample points: the start-bit sample is CLK_DIV/2 cycles after the edge-detect cycle. Each later sample is exactly CLK_DIV cycles after the previous one.
- On the stop-sample cycle, the push and any error pulse take effect at the next clock edge. From that edge:
  - valid_o, level_o and rts reflect the new byte;
  - an error pulse lasts exactly 1 cycle.
- After STOP the FSM is in IDLE and can detect a new start edge on the very next cycle. Back-to-back frames with a 1-bit stop are supported.
- A pop is visible on level_o, valid_o and rts one cycle after the handshake cycle.

## Test plan
Benches use CLK_DIV = 16, DEPTH_LOG2 = 2, RTS_MARGIN = 1 unless stated.
- **Reset:** hold reset 5 cycles with rxd = 1 -> all outputs 0 during reset; rts = 1 on the first post-reset cycle; valid_o stays 0.
- **Single byte:** ready_i = 0, send 0xA5 as 8N1 -> exactly one push; data_o = 0xA5, level_o = 1, no error pulses. Then ready_i = 1 for 1 cycle -> valid_o = 0, level_o = 0.
- **Glitch and frame error:**
  - rxd low for 4 cycles, then high -> no push and no error; FSM returns to IDLE.
  - Frame 0x3C with stop bit 0, then line held low for 20 bit times -> exactly one frame_err_o pulse, no push, no further events.
  - Then line high, send 0x3C correctly -> 0x3C received.
- **Fill and overrun:** ready_i = 0, send 0x01..0x05 back-to-back ->
  - rts falls after the 3rd push (level 3);
  - overrun_err_o pulses once at the 5th stop sample;
  - FIFO holds 0x01..0x04 at level 4.
  - Drain with ready_i = 1 -> bytes emerge in order 01, 02, 03, 04; rts returns high once level ≤ 2.
- **Simultaneous push and pop at full:** with level = 4 and ready_i = 1 on the stop-sample cycle of 0x77 -> no overrun; level stays 4; 0x77 is last in order.
- **Reset mid-frame:**
  - Assert reset during DATA of 0xFF -> FIFO empty and FSM in IDLE one cycle after release.
  - Keep rxd idle 1 frame, then send 0x5A -> only 0x5A is received.

Source files
------------

// File: rtl/uart_rx_flow_if.sv
// Byte stream leaving the UART receiver: FIFO head, occupancy and the
// valid/ready handshake used by the downstream consumer to drain it.
interface uart_rx_flow_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          data_o;
  logic                valid_o;
  logic                ready_i;
  logic [DEPTH_LOG2:0] level_o;

  // Receiver side: produces bytes and occupancy, observes the consumer's ready.
  modport master (
    output data_o,
    output valid_o,
    output level_o,
    input  ready_i
  );

  // Consumer side: observes bytes and occupancy, drives ready.
  modport slave (
    input  data_o,
    input  valid_o,
    input  level_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx_flow.sv
// 8N1 UART receiver with a show-ahead byte FIFO and RTS flow control.
// rxd is synchronized, framed by a counter-driven FSM sampling mid-bit,
// and completed bytes are buffered until the consumer drains them.
module uart_rx_flow #(
  parameter int CLK_DIV    = 868,
  parameter int DEPTH_LOG2 = 4,
  parameter int RTS_MARGIN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  output logic             rts,
  uart_rx_flow_if.master   out_if,
  output logic             frame_err_o,
  output logic             overrun_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  localparam logic [15:0]           CNT_HALF  = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0]           CNT_FULL  = 16'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0]      LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]      RTS_LIMIT = LVL_W'(DEPTH - RTS_MARGIN);
  localparam logic [LVL_W-1:0]      LVL_ONE   = LVL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // Input synchronizer and edge history
  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

  // Framing FSM
  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic        frame_err_q, overrun_err_q;

  // FIFO
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  rts_q;

  logic valid, sample, pop, can_accept, stop_sample, push;

  // Bring the asynchronous line into the clock domain and keep one cycle of history.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign valid       = (level_q != '0);
  assign sample      = (state_q != IDLE) && (cnt_q == '0);
  assign pop         = valid && out_if.ready_i;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign can_accept  = (level_q != LVL_FULL) || pop;
  assign stop_sample = (state_q == STOP) && sample;
  assign push        = stop_sample && rxd_sync_q && can_accept;

  // Frame the serial bits: start validation, LSB-first data, stop check and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      if (state_q != IDLE) begin
        cnt_q <= sample ? CNT_FULL : cnt_q - 16'd1;
      end
      case (state_q)
        IDLE: begin
          // Only a 1->0 transition starts a frame; a line stuck low stays idle.
          if (rxd_prev_q && !rxd_sync_q) begin
            state_q <= START;
            cnt_q   <= CNT_HALF;
          end
        end
        START: begin
          if (sample) begin
            if (!rxd_sync_q) begin
              state_q <= DATA;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shift_q <= {rxd_sync_q, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (sample) begin
            state_q <= IDLE;
            if (!rxd_sync_q) begin
              frame_err_q <= 1'b1;
            end else if (!can_accept) begin
              overrun_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store completed bytes at the write pointer.
  // NOTE: the byte array has no reset; occupancy and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // Post-update occupancy, used both for the level register and for RTS.
  // NOTE: the default assignment first keeps this purely combinational (no latch).
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!push && pop) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Advance pointers and occupancy; throttle the remote end while reserve slots run low.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rts_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      level_q <= level_d;
      rts_q   <= (level_d < RTS_LIMIT);
    end
  end

  // The head entry is only meaningful while valid; force zero otherwise for a clean reset view.
  assign out_if.data_o  = valid ? mem_q[rd_ptr_q] : 8'h00;
  assign out_if.valid_o = valid;
  assign out_if.level_o = level_q;
  assign rts            = rts_q;
  assign frame_err_o    = frame_err_q;
  assign overrun_err_o  = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_flow.sv
// Directed bench for uart_rx_flow: 8N1 frames driven bit by bit with
// CLK_DIV = 16, DEPTH_LOG2 = 2, RTS_MARGIN = 1; expected values hand-computed.
module tb_uart_rx_flow;

  localparam int CLK_DIV = 16;

  logic clk = 1'b0;
  logic reset;
  logic rxd;
  logic rts;
  logic frame_err_o, overrun_err_o;

  int checks = 0;
  int failures = 0;
  int frame_pulses = 0;
  int overrun_pulses = 0;

  uart_rx_flow_if #(.DEPTH_LOG2(2)) bus ();

  uart_rx_flow #(
    .CLK_DIV   (CLK_DIV),
    .DEPTH_LOG2(2),
    .RTS_MARGIN(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .rts          (rts),
    .out_if       (bus.master),
    .frame_err_o  (frame_err_o),
    .overrun_err_o(overrun_err_o)
  );

  always #5 clk = ~clk;

  // Count high cycles of each error output outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err_o)   frame_pulses++;
      if (overrun_err_o) overrun_pulses++;
    end
  end

  // Advance n clock edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; optionally raise ready_i exactly on the stop-sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pop_at_stop);
    rxd = 1'b0;
    tick(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CLK_DIV);
    end
    rxd = stop_bit;
    if (pop_at_stop) begin
      tick(10);
      bus.ready_i = 1'b1;
      tick(1);
      bus.ready_i = 1'b0;
      tick(5);
    end else begin
      tick(CLK_DIV);
    end
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rxd = 1'b1;
    bus.ready_i = 1'b0;
    tick(3);
    checks++; if (rts !== 1'b0) begin failures++; $display("FAIL reset_rts got=%b exp=0", rts); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    checks++; if (bus.level_o !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level_o); end
    checks++; if (bus.data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.data_o); end
    checks++; if (frame_err_o !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err_o); end
    checks++; if (overrun_err_o !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun_err_o); end
    tick(2);
    reset = 1'b0;
    tick(1);
    checks++; if (rts !== 1'b1) begin failures++; $display("FAIL post_reset_rts got=%b exp=1", rts); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", bus.valid_o); end
    tick(4);
  endtask

  task automatic test_single_byte;
    int f0, o0;
    f0 = frame_pulses;
    o0 = overrun_pulses;
    bus.ready_i = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0);
    checks++; if (bus.level_o !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", bus.level_o); end
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.valid_o); end
    checks++; if (bus.data_o !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", bus.data_o); end
    checks++; if (frame_pulses - f0 !== 0) begin failures++; $display("FAIL single_frame_err got=%0d exp=0", frame_pulses - f0); end
    checks++; if (overrun_pulses - o0 !== 0) begin failures++; $display("FAIL single_overrun got=%0d exp=0", overrun_pulses - o0); end
    bus.ready_i = 1'b1;
    tick(1);
    bus.ready_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", bus.valid_o); end
    checks++; if (bus.level_o !== 3'd0) begin failures++; $display("FAIL single_pop_level got=%0d exp=0", bus.level_o); end
  endtask

  task automatic test_glitch_and_frame_error;
    int f0, o0;
    f0 = frame_pulses;
    o0 = overrun_pulses;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    checks++; if (bus.level_o !== 3'd0) begin failures++; $display("FAIL glitch_level got=%0d exp=0", bus.level_o); end
    checks++; if (frame_pulses - f0 !== 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", frame_pulses - f0); end
    // Bad stop bit, then keep the line low for 20 bit times.
    send_frame(8'h3C, 1'b0, 1'b0);
    rxd = 1'b0;
    tick(20 * CLK_DIV);
    checks++; if (frame_pulses - f0 !== 1) begin failures++; $display("FAIL frame_err_count got=%0d exp=1", frame_pulses - f0); end
    checks++; if (bus.level_o !== 3'd0) begin failures++; $display("FAIL frame_err_level got=%0d exp=0", bus.level_o); end
    checks++; if (overrun_pulses - o0 !== 0) begin failures++; $display("FAIL frame_err_overrun got=%0d exp=0", overrun_pulses - o0); end
    rxd = 1'b1;
    tick(2 * CLK_DIV);
    send_frame(8'h3C, 1'b1, 1'b0);
    checks++; if (bus.level_o !== 3'd1) begin failures++; $display("FAIL recover_level got=%0d exp=1", bus.level_o); end
    checks++; if (bus.data_o !== 8'h3C) begin failures++; $display("FAIL recover_data got=%h exp=3c", bus.data_o); end
    checks++; if (frame_pulses - f0 !== 1) begin failures++; $display("FAIL recover_frame_err got=%0d exp=1", frame_pulses - f0); end
    bus.ready_i = 1'b1;
    tick(1);
    bus.ready_i = 1'b0;
  endtask

  task automatic test_fill_overrun;
    logic [7:0] exp_bytes [4];
    logic [2:0] lvl_after [5];
    logic       rts_after [5];
    int o0, f0;
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    lvl_after = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    rts_after = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    o0 = overrun_pulses;
    f0 = frame_pulses;
    bus.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'(i + 1), 1'b1, 1'b0);
      checks++; if (bus.level_o !== lvl_after[i]) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, bus.level_o, lvl_after[i]); end
      checks++; if (rts !== rts_after[i]) begin failures++; $display("FAIL fill_rts[%0d] got=%b exp=%b", i, rts, rts_after[i]); end
    end
    checks++; if (overrun_pulses - o0 !== 1) begin failures++; $display("FAIL overrun_count got=%0d exp=1", overrun_pulses - o0); end
    checks++; if (frame_pulses - f0 !== 0) begin failures++; $display("FAIL overrun_frame_err got=%0d exp=0", frame_pulses - f0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.valid_o !== 1'b1 || bus.data_o !== exp_bytes[i]) begin failures++; $display("FAIL drain_data[%0d] got=%h valid=%b exp=%h", i, bus.data_o, bus.valid_o, exp_bytes[i]); end
      bus.ready_i = 1'b1;
      tick(1);
      checks++; if (bus.level_o !== 3'(3 - i)) begin failures++; $display("FAIL drain_level[%0d] got=%0d exp=%0d", i, bus.level_o, 3 - i); end
      checks++; if (rts !== ((3 - i) < 3)) begin failures++; $display("FAIL drain_rts[%0d] got=%b exp=%b", i, rts, ((3 - i) < 3)); end
    end
    bus.ready_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.valid_o); end
  endtask

  task automatic test_push_pop_full;
    logic [7:0] exp_bytes [4];
    int o0;
    exp_bytes = '{8'h22, 8'h33, 8'h44, 8'h77};
    bus.ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    checks++; if (bus.level_o !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", bus.level_o); end
    o0 = overrun_pulses;
    send_frame(8'h77, 1'b1, 1'b1);
    checks++; if (overrun_pulses - o0 !== 0) begin failures++; $display("FAIL pushpop_overrun got=%0d exp=0", overrun_pulses - o0); end
    checks++; if (bus.level_o !== 3'd4) begin failures++; $display("FAIL pushpop_level got=%0d exp=4", bus.level_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.valid_o !== 1'b1 || bus.data_o !== exp_bytes[i]) begin failures++; $display("FAIL pushpop_order[%0d] got=%h valid=%b exp=%h", i, bus.data_o, bus.valid_o, exp_bytes[i]); end
      bus.ready_i = 1'b1;
      tick(1);
    end
    bus.ready_i = 1'b0;
    checks++; if (bus.level_o !== 3'd0) begin failures++; $display("FAIL pushpop_drained got=%0d exp=0", bus.level_o); end
  endtask

  task automatic test_reset_mid_frame;
    int f0;
    bus.ready_i = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0);
    checks++; if (bus.level_o !== 3'd1) begin failures++; $display("FAIL pre_abort_level got=%0d exp=1", bus.level_o); end
    f0 = frame_pulses;
    // Start bit and three data bits of 0xFF, then reset while in DATA.
    rxd = 1'b0;
    tick(CLK_DIV);
    rxd = 1'b1;
    tick(3 * CLK_DIV);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    checks++; if (bus.level_o !== 3'd0) begin failures++; $display("FAIL abort_level got=%0d exp=0", bus.level_o); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", bus.valid_o); end
    checks++; if (rts !== 1'b1) begin failures++; $display("FAIL abort_rts got=%b exp=1", rts); end
    tick(10 * CLK_DIV);
    send_frame(8'h5A, 1'b1, 1'b0);
    checks++; if (bus.level_o !== 3'd1) begin failures++; $display("FAIL after_abort_level got=%0d exp=1", bus.level_o); end
    checks++; if (bus.data_o !== 8'h5A) begin failures++; $display("FAIL after_abort_data got=%h exp=5a", bus.data_o); end
    checks++; if (frame_pulses - f0 !== 0) begin failures++; $display("FAIL after_abort_frame_err got=%0d exp=0", frame_pulses - f0); end
    bus.ready_i = 1'b1;
    tick(1);
    bus.ready_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL after_abort_empty got=%b exp=0", bus.valid_o); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch_and_frame_error();
    test_fill_overrun();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
